div_issue_ctrl: RTL and testbench

Front-end and writeback controller for the fixed-latency signed pipelined divider. Accepts valid/ready divide requests carrying a tag, registers the operands into the divider, and tracks each request through a matching sideband pipe. Applies the divide-by-zero and overflow overrides, then buffers results in an output FIFO. A credit scheme guarantees the non-stallable divider never produces a result the FIFO cannot hold.

---
 rtl/div_issue_ctrl_if.sv | 36 +++
 rtl/div_issue_ctrl.sv | 172 +++++++++++++++++
 tb/tb_div_issue_ctrl.sv | 278 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/div_issue_ctrl_if.sv
// rtl/div_issue_ctrl_if.sv - request/result handshake bundle for div_issue_ctrl
//
// Purpose: groups the request channel (in_*) and result channel (out_*) of
// the divider issue controller.
// Ports (signals):
//   in_valid/in_ready/in_a/in_b/in_tag          request channel, producer -> controller
//   out_valid/out_ready/out_result/out_tag/
//   out_div0/out_ovf                            result channel, controller -> consumer
// Modports: master = requester/consumer side, slave = controller side.
interface div_issue_ctrl_if #(
  parameter int DATA_LEN = 32,
  parameter int TAG_LEN  = 4
);
  logic                in_valid;
  logic                in_ready;
  logic [DATA_LEN-1:0] in_a;
  logic [DATA_LEN-1:0] in_b;
  logic [TAG_LEN-1:0]  in_tag;

  logic                out_valid;
  logic                out_ready;
  logic [DATA_LEN-1:0] out_result;
  logic [TAG_LEN-1:0]  out_tag;
  logic                out_div0;
  logic                out_ovf;

  modport master (
    output in_valid, in_a, in_b, in_tag, out_ready,
    input  in_ready, out_valid, out_result, out_tag, out_div0, out_ovf
  );

  modport slave (
    input  in_valid, in_a, in_b, in_tag, out_ready,
    output in_ready, out_valid, out_result, out_tag, out_div0, out_ovf
  );
endinterface

// File: rtl/div_issue_ctrl.sv
// rtl/div_issue_ctrl.sv - issue/writeback controller for a fixed-latency signed divider
//
// Purpose: registers accepted operands into an external non-stallable divider,
// carries tag and exception flags down a sideband pipe aligned with the
// divider, applies the divide-by-zero / overflow overrides and buffers
// results in an in-order FIFO. A credit counter (outstanding) bounds
// accepted-but-unpopped requests to FIFO_DEPTH so the FIFO never overflows.
// Ports:
//   clk, reset_n        clock, asynchronous active-low reset
//   bus (slave)         request channel in_* and result channel out_*
//   div_a, div_b        registered operands to the divider
//   div_result          quotient from the divider, DIV_LATENCY cycles later
//   outstanding         requests accepted and not yet popped
module div_issue_ctrl #(
  parameter int DATA_LEN    = 32,
  parameter int TAG_LEN     = 4,
  parameter int DIV_LATENCY = 6,
  parameter int FIFO_DEPTH  = 16
) (
  input  logic                             clk,
  input  logic                             reset_n,
  div_issue_ctrl_if.slave                  bus,
  output logic [DATA_LEN-1:0]              div_a,
  output logic [DATA_LEN-1:0]              div_b,
  input  logic [DATA_LEN-1:0]              div_result,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]  outstanding
);

  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

  localparam logic [DATA_LEN-1:0] MIN_VAL = {1'b1, {(DATA_LEN-1){1'b0}}};
  localparam logic [DATA_LEN-1:0] NEG_ONE = '1;
  localparam logic [DATA_LEN-1:0] ONE     = DATA_LEN'(1);

  typedef struct packed {
    logic               valid;
    logic [TAG_LEN-1:0] tag;
    logic               div0;
    logic               ovf;
  } sb_t;

  typedef struct packed {
    logic [DATA_LEN-1:0] result;
    logic [TAG_LEN-1:0]  tag;
    logic                div0;
    logic                ovf;
  } entry_t;

  // sb_q[0] is the issue stage (aligned with div_a/div_b); sb_q[DIV_LATENCY]
  // is the tail, aligned with div_result.
  sb_t    sb_q  [DIV_LATENCY+1];
  sb_t    sb_d  [DIV_LATENCY+1];
  entry_t mem_q [FIFO_DEPTH];
  entry_t mem_d [FIFO_DEPTH];

  logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]    count_q, count_d;
  logic [CNT_W-1:0]    outstanding_q, outstanding_d;
  logic                in_ready_q, in_ready_d;
  logic [DATA_LEN-1:0] div_a_q, div_a_d;
  logic [DATA_LEN-1:0] div_b_q, div_b_d;

  logic   accept;
  logic   pop;
  logic   in_div0;
  logic   in_ovf;
  sb_t    tail;
  entry_t wr_entry;
  entry_t head;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    if (p == PTR_W'(FIFO_DEPTH - 1)) return '0;
    return p + PTR_W'(1);
  endfunction

  always_comb begin
    accept  = bus.in_valid && in_ready_q;
    pop     = (count_q != '0) && bus.out_ready;
    in_div0 = (bus.in_b == '0);
    in_ovf  = (bus.in_a == MIN_VAL) && (bus.in_b == NEG_ONE);

    // Excepting requests send a harmless divisor; their result is overridden.
    div_a_d = div_a_q;
    div_b_d = div_b_q;
    if (accept) begin
      div_a_d = bus.in_a;
      div_b_d = (in_div0 || in_ovf) ? ONE : bus.in_b;
    end

    sb_d[0] = '0;
    if (accept) begin
      sb_d[0].valid = 1'b1;
      sb_d[0].tag   = bus.in_tag;
      sb_d[0].div0  = in_div0;
      sb_d[0].ovf   = in_ovf;
    end
    for (int i = 1; i <= DIV_LATENCY; i++) begin
      sb_d[i] = sb_q[i-1];
    end

    tail            = sb_q[DIV_LATENCY];
    wr_entry.tag    = tail.tag;
    wr_entry.div0   = tail.div0;
    wr_entry.ovf    = tail.ovf;
    wr_entry.result = tail.div0 ? NEG_ONE : (tail.ovf ? MIN_VAL : div_result);

    // Credits guarantee a write never lands on a full FIFO, so no full check.
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    if (tail.valid) begin
      mem_d[wr_ptr_q] = wr_entry;
      wr_ptr_d        = ptr_inc(wr_ptr_q);
    end
    rd_ptr_d = pop ? ptr_inc(rd_ptr_q) : rd_ptr_q;

    count_d = count_q;
    case ({tail.valid, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase

    outstanding_d = outstanding_q;
    case ({accept, pop})
      2'b10:   outstanding_d = outstanding_q + CNT_W'(1);
      2'b01:   outstanding_d = outstanding_q - CNT_W'(1);
      default: outstanding_d = outstanding_q;
    endcase

    // Registered so in_ready has no path from in_valid/out_ready and stays
    // low throughout reset.
    in_ready_d = (outstanding_d < CNT_W'(FIFO_DEPTH));
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i <= DIV_LATENCY; i++) sb_q[i] <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
      outstanding_q <= '0;
      in_ready_q    <= 1'b0;
      div_a_q       <= '0;
      div_b_q       <= ONE;
    end else begin
      sb_q          <= sb_d;
      mem_q         <= mem_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      count_q       <= count_d;
      outstanding_q <= outstanding_d;
      in_ready_q    <= in_ready_d;
      div_a_q       <= div_a_d;
      div_b_q       <= div_b_d;
    end
  end

  assign head           = mem_q[rd_ptr_q];
  assign bus.in_ready   = in_ready_q;
  assign bus.out_valid  = (count_q != '0);
  assign bus.out_result = bus.out_valid ? head.result : '0;
  assign bus.out_tag    = bus.out_valid ? head.tag : '0;
  assign bus.out_div0   = bus.out_valid && head.div0;
  assign bus.out_ovf    = bus.out_valid && head.ovf;
  assign div_a          = div_a_q;
  assign div_b          = div_b_q;
  assign outstanding    = outstanding_q;

endmodule

// File: tb/tb_div_issue_ctrl.sv
// tb/tb_div_issue_ctrl.sv - self-checking bench for div_issue_ctrl
module tb_div_issue_ctrl;

  localparam int DL  = 32;
  localparam int TL  = 4;
  localparam int LAT = 6;
  localparam int DEP = 16;
  localparam logic [31:0] MINV = 32'h8000_0000;

  logic        clk;
  logic        reset_n;
  logic [31:0] div_a, div_b, div_result;
  logic [4:0]  outstanding;

  div_issue_ctrl_if #(.DATA_LEN(DL), .TAG_LEN(TL)) bus ();

  div_issue_ctrl #(.DATA_LEN(DL), .TAG_LEN(TL), .DIV_LATENCY(LAT), .FIFO_DEPTH(DEP)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .bus        (bus),
    .div_a      (div_a),
    .div_b      (div_b),
    .div_result (div_result),
    .outstanding(outstanding)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Stand-in for the external pipelined divider.
  logic [31:0] dpipe [LAT];
  function automatic logic [31:0] stand_div(input logic [31:0] a, input logic [31:0] b);
    if (b == 32'd0) return 32'd0;
    return $signed(a) / $signed(b);
  endfunction
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < LAT; i++) dpipe[i] <= '0;
    end else begin
      dpipe[0] <= stand_div(div_a, div_b);
      for (int i = 1; i < LAT; i++) dpipe[i] <= dpipe[i-1];
    end
  end
  assign div_result = dpipe[LAT-1];

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  // Reference model: results straight from the divide/exception rules.
  typedef struct {
    logic [31:0] res;
    logic [3:0]  tag;
    logic        div0;
    logic        ovf;
  } exp_t;
  exp_t exp_q[$];
  int   pops = 0;
  bit   mon_en = 0;

  function automatic exp_t model(input logic [31:0] a, input logic [31:0] b, input logic [3:0] tag);
    exp_t e;
    e.tag = tag; e.div0 = 1'b0; e.ovf = 1'b0;
    if (b == 32'd0) begin
      e.res = 32'hFFFF_FFFF; e.div0 = 1'b1;
    end else if (a == MINV && b == 32'hFFFF_FFFF) begin
      e.res = MINV; e.ovf = 1'b1;
    end else begin
      longint q;
      q = longint'($signed(a)) / longint'($signed(b));
      e.res = q[31:0];
    end
    return e;
  endfunction

  logic        prev_stall = 1'b0;
  logic [31:0] prev_res;
  logic [3:0]  prev_tag;
  logic        prev_d0, prev_ov;

  always @(negedge clk) begin
    if (mon_en) begin
      chk("outstanding", 64'(outstanding), 64'(exp_q.size()));
      chk("in_ready_credit", 64'(bus.in_ready), 64'(exp_q.size() < DEP));
      chk("no_overflow", 64'(outstanding <= 5'(DEP)), 64'd1);
      if (prev_stall) begin
        chk("hold_result", {32'd0, bus.out_result}, {32'd0, prev_res});
        chk("hold_meta", {58'd0, bus.out_valid, bus.out_tag, bus.out_div0, bus.out_ovf},
            {58'd0, 1'b1, prev_tag, prev_d0, prev_ov});
      end
      if (bus.out_valid && bus.out_ready) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_pop", 64'd1, 64'd0);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          chk("mon_result", {32'd0, bus.out_result}, {32'd0, e.res});
          chk("mon_meta", {58'd0, bus.out_tag, bus.out_div0, bus.out_ovf}, {58'd0, e.tag, e.div0, e.ovf});
          pops++;
        end
      end
      if (bus.in_valid && bus.in_ready) exp_q.push_back(model(bus.in_a, bus.in_b, bus.in_tag));
      prev_stall = bus.out_valid && !bus.out_ready;
      prev_res   = bus.out_result;
      prev_tag   = bus.out_tag;
      prev_d0    = bus.out_div0;
      prev_ov    = bus.out_ovf;
    end else begin
      prev_stall = 1'b0;
    end
  end

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [3:0]  tag;
    logic [31:0] res;
    logic        div0;
    logic        ovf;
  } vec_t;
  vec_t vt[11];

  task automatic run_single(input vec_t v, input string nm);
    int n;
    logic [31:0] exp_b;
    exp_b = (v.div0 || v.ovf) ? 32'd1 : v.b;
    bus.out_ready = 1'b1;
    bus.in_valid = 1'b1; bus.in_a = v.a; bus.in_b = v.b; bus.in_tag = v.tag;
    chk({nm, "_in_ready"}, 64'(bus.in_ready), 64'd1);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    chk({nm, "_div_a"}, {32'd0, div_a}, {32'd0, v.a});
    chk({nm, "_div_b"}, {32'd0, div_b}, {32'd0, exp_b});
    n = 1;
    while (!bus.out_valid && n < 30) begin
      @(posedge clk); #1; n++;
    end
    chk({nm, "_latency"}, 64'(n), 64'd8);
    chk({nm, "_result"}, {32'd0, bus.out_result}, {32'd0, v.res});
    chk({nm, "_tag_flags"}, {58'd0, bus.out_tag, bus.out_div0, bus.out_ovf}, {58'd0, v.tag, v.div0, v.ovf});
    @(posedge clk); #1;
    chk({nm, "_drained"}, {62'd0, bus.out_valid, (outstanding == 5'd0)}, 64'd1);
  endtask

  task automatic rand_ops(output logic [31:0] a, output logic [31:0] b);
    int r;
    r = $urandom_range(0, 7);
    a = $urandom; b = $urandom;
    case (r)
      0: b = 32'd0;
      1: begin a = MINV; b = 32'hFFFF_FFFF; end
      2: begin
        a = 32'($urandom_range(0, 2000)) - 32'd1000;
        b = 32'($urandom_range(1, 20));
        if ($urandom_range(0, 1) == 1) b = -b;
      end
      3: a = MINV;
      default: ;
    endcase
  endtask

  initial begin
    int drops, acc, cyc, pops0, vis;
    logic [31:0] ra, rb;
    vec_t v;

    vt[0]  = '{32'd100,        32'hFFFF_FFF9, 4'd3,  32'hFFFF_FFF2, 1'b0, 1'b0};
    vt[1]  = '{32'd5,          32'd0,         4'd1,  32'hFFFF_FFFF, 1'b1, 1'b0};
    vt[2]  = '{MINV,           32'hFFFF_FFFF, 4'd2,  MINV,          1'b0, 1'b1};
    vt[3]  = '{32'hFFFF_FF9C,  32'd7,         4'd4,  32'hFFFF_FFF2, 1'b0, 1'b0};
    vt[4]  = '{32'd7,          32'hFFFF_FFF9, 4'd5,  32'hFFFF_FFFF, 1'b0, 1'b0};
    vt[5]  = '{MINV,           32'd2,         4'd6,  32'hC000_0000, 1'b0, 1'b0};
    vt[6]  = '{32'd0,          32'd5,         4'd7,  32'd0,         1'b0, 1'b0};
    vt[7]  = '{32'hFFFF_FFFF,  32'hFFFF_FFFF, 4'd8,  32'd1,         1'b0, 1'b0};
    vt[8]  = '{MINV,           32'd0,         4'd9,  32'hFFFF_FFFF, 1'b1, 1'b0};
    vt[9]  = '{32'h7FFF_FFFF,  32'hFFFF_FFFF, 4'd15, 32'h8000_0001, 1'b0, 1'b0};
    vt[10] = '{32'd9,          32'd3,         4'd10, 32'd3,         1'b0, 1'b0};

    reset_n = 1'b0;
    bus.in_valid = 1'b0; bus.in_a = '0; bus.in_b = '0; bus.in_tag = '0; bus.out_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready", 64'(bus.in_ready), 64'd0);
    chk("rst_out", {bus.out_result, 26'd0, bus.out_tag, bus.out_valid, bus.out_div0, bus.out_ovf}, 64'd0);
    chk("rst_div_ab", {div_a, div_b}, {32'd0, 32'd1});
    chk("rst_outstanding", 64'(outstanding), 64'd0);
    reset_n = 1'b1;
    @(posedge clk); #1;
    chk("rel_in_ready", 64'(bus.in_ready), 64'd1);
    mon_en = 1;

    for (int i = 0; i < 10; i++) run_single(vt[i], $sformatf("vec%0d", i));

    // Back-to-back random traffic with the consumer always ready.
    drops = 0;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 50; i++) begin
      rand_ops(ra, rb);
      bus.in_valid = 1'b1; bus.in_a = ra; bus.in_b = rb; bus.in_tag = 4'(i % 16);
      if (!bus.in_ready) drops++;
      @(posedge clk); #1;
    end
    bus.in_valid = 1'b0;
    chk("b2b_no_drop", 64'(drops), 64'd0);
    cyc = 0;
    while (exp_q.size() != 0 && cyc < 50) begin @(posedge clk); #1; cyc++; end
    chk("b2b_drained", 64'(exp_q.size()), 64'd0);

    // Backpressure: credits stop acceptance at FIFO_DEPTH.
    bus.out_ready = 1'b0;
    acc = 0;
    for (int i = 0; i < 30; i++) begin
      rand_ops(ra, rb);
      bus.in_valid = 1'b1; bus.in_a = ra; bus.in_b = rb; bus.in_tag = 4'($urandom);
      if (bus.in_ready) acc++;
      @(posedge clk); #1;
    end
    bus.in_valid = 1'b0;
    chk("bp_accepts", 64'(acc), 64'(DEP));
    chk("bp_in_ready", 64'(bus.in_ready), 64'd0);
    chk("bp_outstanding", 64'(outstanding), 64'(DEP));
    pops0 = pops; cyc = 0;
    while (exp_q.size() != 0 && cyc < 300) begin
      bus.out_ready = (cyc % 3 == 0);
      @(posedge clk); #1; cyc++;
    end
    bus.out_ready = 1'b0;
    chk("bp_drained", 64'(exp_q.size()), 64'd0);
    chk("bp_pop_count", 64'(pops - pops0), 64'(DEP));

    // Reset with 3 results buffered and 5 in flight.
    for (int i = 0; i < 3; i++) begin
      bus.in_valid = 1'b1; bus.in_a = 32'(100 + i); bus.in_b = 32'd2; bus.in_tag = 4'(i);
      @(posedge clk); #1;
    end
    bus.in_valid = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    for (int i = 0; i < 5; i++) begin
      bus.in_valid = 1'b1; bus.in_a = 32'(200 + i); bus.in_b = 32'd3; bus.in_tag = 4'(8 + i);
      @(posedge clk); #1;
    end
    bus.in_valid = 1'b0;
    mon_en = 0;
    chk("pre_rst_state", {62'd0, bus.out_valid, (outstanding == 5'd8)}, 64'd3);
    #2 reset_n = 1'b0;
    #1;
    chk("async_rst_out_valid", 64'(bus.out_valid), 64'd0);
    chk("async_rst_outstanding", 64'(outstanding), 64'd0);
    chk("async_rst_in_ready", 64'(bus.in_ready), 64'd0);
    exp_q.delete();
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk); #1;
    chk("rel2_in_ready", 64'(bus.in_ready), 64'd1);
    mon_en = 1;
    run_single(vt[10], "post_rst");
    vis = 0;
    for (int i = 0; i < 20; i++) begin
      if (bus.out_valid) vis++;
      @(posedge clk); #1;
    end
    chk("no_stale_output", 64'(vis), 64'd0);

    mon_en = 0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
